// File: rtl/tile_operand_skewer_pkg.sv
// tile_operand_skewer_pkg: shared defaults, FSM encoding and clog2 helper for the operand skewer.
package tile_operand_skewer_pkg;
   localparam int DEF_NUM_TILES = 4;
   localparam int DEF_TILE_SIZE = 8;
   localparam int DEF_DWIDTH = 8;
   localparam int DEF_SKEW = 8;
   typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2} state_t;
   function automatic int clog2(input int v);
      int r;
      for (r = 0; (1 << r) < v; r++) begin
      end
      return r;
   endfunction
endpackage

// File: rtl/tile_operand_skewer_skew_delay_line.sv
// skew_delay_line: DEPTH-stage data+valid shift register with sync reset/clear; DEPTH=0 passes through.
module skew_delay_line #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1
) (
   input logic clk,
   input logic reset,
   input logic clear,
   input logic [WIDTH-1:0] in_data,
   input logic in_valid,
   output logic [WIDTH-1:0] out_data,
   output logic out_valid
);
   if (DEPTH == 0) begin : g_pass
      logic unused;
      assign unused = &{1'b0, clk, reset, clear};
      assign out_data = in_data;
      assign out_valid = in_valid;
   end else begin : g_sr
      logic [DEPTH-1:0][WIDTH:0] sr;
      always_ff @(posedge clk)
         if (reset || clear) sr <= '0;
         else begin
            for (int i = DEPTH - 1; i > 0; i--) sr[i] <= sr[i-1];
            sr[0] <= {in_valid, in_data};
         end
      assign {out_valid, out_data} = sr[DEPTH-1];
   end
endmodule

// File: rtl/tile_operand_skewer.sv
// tile_operand_skewer: delays slice k of the operand bus by k*SKEW cycles with pass framing and tile masking.
module tile_operand_skewer
   import tile_operand_skewer_pkg::*;
#(
   parameter int NUM_TILES = DEF_NUM_TILES,
   parameter int TILE_SIZE = DEF_TILE_SIZE,
   parameter int DWIDTH = DEF_DWIDTH,
   parameter int SKEW = DEF_SKEW,
   localparam int TILE_W = TILE_SIZE * DWIDTH,
   localparam int CNT_W = clog2(NUM_TILES + 1)
) (
   input logic clk,
   input logic reset,
   input logic start,
   input logic [CNT_W-1:0] active_tiles,
   input logic in_valid,
   input logic in_last,
   input logic [NUM_TILES*TILE_W-1:0] in_data,
   output logic [NUM_TILES*TILE_W-1:0] out_data,
   output logic [NUM_TILES-1:0] out_valid,
   output logic busy,
   output logic done
);
   localparam int DRAIN_RAW = clog2((NUM_TILES - 1) * SKEW + 1);
   localparam int DRAIN_W = DRAIN_RAW > 0 ? DRAIN_RAW : 1;
   state_t state;
   logic [DRAIN_W-1:0] cnt;
   logic [CNT_W-1:0] act;
   logic accept, clear;
   logic [NUM_TILES*TILE_W-1:0] gated, dl_data;
   logic [NUM_TILES-1:0] dl_valid;
   assign accept = in_valid && state == STREAM && !reset;
   assign gated = accept ? in_data : '0;
   assign clear = state == IDLE && start;
   assign busy = state != IDLE;
   assign done = state == DRAIN && cnt == '0;
   always_ff @(posedge clk)
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         act <= CNT_W'(1);
      end else if (state == IDLE) begin
         if (start) begin
            state <= STREAM;
            act <= active_tiles == '0 ? CNT_W'(1) :
                   active_tiles > CNT_W'(NUM_TILES) ? CNT_W'(NUM_TILES) : active_tiles;
         end
      end else if (state == STREAM) begin
         if (accept && in_last) begin
            state <= DRAIN;
            cnt <= DRAIN_W'((int'(act) - 1) * SKEW);
         end
      end else if (cnt == '0) state <= IDLE;
      else cnt <= cnt - 1'b1;
   // Unused slices keep shifting but are zeroed at the output.
   for (genvar k = 0; k < NUM_TILES; k++) begin : g_slice
      skew_delay_line #(.WIDTH(TILE_W), .DEPTH(k * SKEW)) u_dl (
         .clk(clk),
         .reset(reset),
         .clear(clear),
         .in_data(gated[k*TILE_W +: TILE_W]),
         .in_valid(accept),
         .out_data(dl_data[k*TILE_W +: TILE_W]),
         .out_valid(dl_valid[k])
      );
      assign out_data[k*TILE_W +: TILE_W] = (CNT_W'(k) < act && !reset) ? dl_data[k*TILE_W +: TILE_W] : '0;
      assign out_valid[k] = CNT_W'(k) < act && !reset && dl_valid[k];
   end
endmodule
